// File: rtl/apb_mem_slave_param.sv
// apb_mem_slave_param
//   Parametrised APB3/APB4 scratch-register slave. A DEPTH x DATA_WIDTH flop
//   array is read and written through the APB access phase, with a fixed
//   number of wait states, per-byte write strobes and PSLVERR on accesses
//   that fall outside the array or are not word aligned.
//
// Parameters
//   DATA_WIDTH   bus width in bits (8, 16, 32 or 64)
//   ADDR_WIDTH   byte-address width of paddr
//   DEPTH        number of implemented words
//   WAIT_STATES  access-phase cycles with pready low before completion (0..15)
//
// Ports
//   pclk     in   clock, rising edge
//   presetn  in   asynchronous reset, active HIGH despite the name
//   psel     in   slave select
//   penable  in   access-phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address
//   pwdata   in   write data
//   pstrb    in   byte-lane write enables
//   prdata   out  read data, non-zero only in a clean read completion cycle
//   pready   out  transfer completion
//   pslverr  out  transfer error, qualified by pready

module apb_mem_slave_param #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(BYTES);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so DEPTH == 2**IDX_W is still representable.
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);
  localparam logic [3:0]     WS      = 4'(WAIT_STATES);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [IDX_W-1:0]        index;
  logic [MEM_AW-1:0]       word;
  logic                    misaligned;
  logic                    err;
  logic                    done;

  assign index = paddr[ADDR_WIDTH-1:LSB];
  // Upper index bits only matter for the range check; they never reach the
  // array because err masks every access they would affect.
  assign word  = index[MEM_AW-1:0];

  // Byte-wide buses have no sub-word address bits, so nothing can misalign.
  generate
    if (LSB == 0) begin : gen_no_align
      assign misaligned = 1'b0;
    end else begin : gen_align
      assign misaligned = |paddr[LSB-1:0];
    end
  endgenerate

  assign err  = ({1'b0, index} >= DEPTH_L) || misaligned;

  // Completion: access phase held for exactly WAIT_STATES extra cycles.
  assign done = (state == ACCESS) && psel && penable && (cnt == WS);

  // Gating with presetn makes the outputs drop the instant reset rises,
  // independent of how the state flops settle.
  assign pready  = done && !presetn;
  assign pslverr = pready && err;
  assign prdata  = (pready && !pwrite && !err) ? mem[word] : '0;

  // NOTE: the storage is a flop array, not a RAM macro, so it can and must be
  // cleared by the asynchronous reset together with the control state.
  always_ff @(posedge pclk or posedge presetn) begin
    if (presetn) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision in this
      // block sees the pre-edge values of state and cnt.
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state <= ACCESS;
            cnt   <= '0;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (cnt < WS) begin
            cnt <= cnt + 4'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (done && pwrite && !err) begin
        for (int k = 0; k < BYTES; k++) begin
          if (pstrb[k]) begin
            mem[word][k*8 +: 8] <= pwdata[k*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave_param.sv
// Testbench for apb_mem_slave_param. Three instances (WAIT_STATES 0, 1, 3)
// share the address/data/control bus and each has its own psel. Expected
// responses are pushed to a scoreboard queue when a transfer is launched and
// popped when the selected instance raises pready.

module tb_apb_mem_slave_param;

  localparam time PERIOD = 10;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  logic [31:0] model [3][64];
  exp_t        sb [$];
  time         done_t;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #(PERIOD / 2) pclk = ~pclk;

  apb_mem_slave_param #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(64), .WAIT_STATES(0)) u_ws0 (
    .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
  );

  apb_mem_slave_param #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(64), .WAIT_STATES(1)) u_ws1 (
    .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
  );

  apb_mem_slave_param #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(64), .WAIT_STATES(3)) u_ws3 (
    .pclk(pclk), .presetn(presetn), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2])
  );

  function automatic int ws_of(input int inst);
    case (inst)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic void clear_models();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 64; j++)
        model[i][j] = 32'h0;
  endfunction

  // Full APB transfer starting at posedge+1; returns at posedge+1 after the
  // completion edge so another call can follow back-to-back.
  task automatic xfer(input int inst, input logic wr, input logic [11:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input string name);
    exp_t e;
    int   idx;
    int   cyc;
    logic ok;
    idx   = int'(addr[11:2]);
    e.err = (idx >= 64) || (addr[1:0] != 2'b00);
    e.data = (wr || e.err) ? 32'h0 : model[inst][idx];
    e.lat = ws_of(inst) + 1;
    sb.push_back(e);

    psel[inst] = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = data; pstrb = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 0; ok = 1'b0;
    while (!ok && cyc < 32) begin
      cyc++;
      @(negedge pclk);
      if (pready[inst]) ok = 1'b1;
      else begin
        @(posedge pclk); #1;
      end
    end

    e = sb.pop_front();
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s timeout: pready never rose within %0d cycles (expected after %0d)", name, cyc, e.lat);
    end else begin
      done_t = $time;
      if (cyc !== e.lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d access cycles, expected %0d", name, cyc, e.lat);
      end
      n_tests++;
      if (prdata[inst] !== e.data) begin
        n_fail++;
        $display("FAIL %s prdata: got %h, expected %h", name, prdata[inst], e.data);
      end
      n_tests++;
      if (pslverr[inst] !== e.err) begin
        n_fail++;
        $display("FAIL %s pslverr: got %b, expected %b", name, pslverr[inst], e.err);
      end
      if (wr && !e.err)
        for (int k = 0; k < 4; k++)
          if (strb[k]) model[inst][idx][k*8 +: 8] = data[k*8 +: 8];
    end
    @(posedge pclk); #1;
    psel[inst] = 1'b0; penable = 1'b0;
  endtask

  task automatic check_idle_outputs(input int inst, input string name);
    n_tests++;
    if (pready[inst] !== 1'b0 || pslverr[inst] !== 1'b0 || prdata[inst] !== 32'h0) begin
      n_fail++;
      $display("FAIL %s inst%0d: pready=%b pslverr=%b prdata=%h, expected 0/0/00000000",
               name, inst, pready[inst], pslverr[inst], prdata[inst]);
    end
  endtask

  task automatic test_reset();
    presetn = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    clear_models();
    #1;
    for (int i = 0; i < 3; i++) check_idle_outputs(i, "reset_outputs");
    repeat (2) @(posedge pclk);
    #1;
    // Reset release and setup phase in the same cycle.
    presetn = 1'b0;
    xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, "reset_read_010");
  endtask

  task automatic test_full();
    xfer(1, 1'b1, 12'h004, 32'hDEADBEEF, 4'hF, "full_write_004");
    xfer(1, 1'b0, 12'h004, 32'h0, 4'h0, "full_read_004");
  endtask

  task automatic test_strobe();
    xfer(1, 1'b1, 12'h004, 32'h11223344, 4'b0101, "strobe_write_004");
    xfer(1, 1'b0, 12'h004, 32'h0, 4'hF, "strobe_read_004");
    xfer(1, 1'b1, 12'h00C, 32'hFFFFFFFF, 4'h0, "strobe_zero_write");
    xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, "strobe_zero_read");
  endtask

  task automatic test_errors();
    xfer(1, 1'b1, 12'h100, 32'h00000055, 4'hF, "err_write_range");
    xfer(1, 1'b0, 12'h002, 32'h0, 4'h0, "err_read_misaligned");
    xfer(1, 1'b1, 12'h001, 32'hCAFEF00D, 4'hF, "err_write_misaligned");
    xfer(1, 1'b0, 12'h000, 32'h0, 4'h0, "err_read_000_after");
    xfer(1, 1'b0, 12'hFFC, 32'h0, 4'h0, "err_read_top");
  endtask

  task automatic test_abort();
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 12'h008; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    check_idle_outputs(1, "abort_wait_cycle");
    #1;
    psel[1] = 1'b0; penable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      check_idle_outputs(1, "abort_after_drop");
    end
    @(posedge pclk); #1;
    xfer(1, 1'b0, 12'h008, 32'h0, 4'h0, "abort_read_008");
  endtask

  task automatic test_no_setup();
    psel[1] = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 12'h004;
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      check_idle_outputs(1, "penable_without_setup");
    end
    @(posedge pclk); #1;
    psel[1] = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  task automatic test_back_to_back();
    time t1;
    int  insts [2] = '{0, 2};
    foreach (insts[n]) begin
      int inst;
      inst = insts[n];
      xfer(inst, 1'b1, 12'h000, 32'hA5A5_0000 + inst, 4'hF, "b2b_write_000");
      t1 = done_t;
      xfer(inst, 1'b1, 12'h004, 32'h5A5A_0000 + inst, 4'hF, "b2b_write_004");
      n_tests++;
      if (done_t - t1 !== PERIOD * (ws_of(inst) + 2)) begin
        n_fail++;
        $display("FAIL b2b_period inst%0d: got %0t, expected %0t", inst, done_t - t1,
                 PERIOD * (ws_of(inst) + 2));
      end
      xfer(inst, 1'b0, 12'h000, 32'h0, 4'h0, "b2b_read_000");
      xfer(inst, 1'b0, 12'h004, 32'h0, 4'h0, "b2b_read_004");
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      logic [11:0] a;
      a = 12'($urandom_range(0, 7)) << 2;
      xfer(1, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "random");
    end
  endtask

  task automatic test_reset_mid();
    xfer(1, 1'b1, 12'h014, 32'h12345678, 4'hF, "mid_prewrite_014");
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h014; pstrb = 4'h0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(negedge pclk);
    n_tests++;
    if (pready[1] !== 1'b1 || prdata[1] !== model[1][5]) begin
      n_fail++;
      $display("FAIL mid_completion: pready=%b prdata=%h, expected 1/%h", pready[1], prdata[1], model[1][5]);
    end
    #2;
    presetn = 1'b1;
    #1;
    check_idle_outputs(1, "mid_reset_immediate");
    @(posedge pclk); #1;
    psel[1] = 1'b0; penable = 1'b0;
    clear_models();
    @(posedge pclk); #1;
    presetn = 1'b0;
    xfer(1, 1'b0, 12'h014, 32'h0, 4'h0, "mid_read_014");
    xfer(1, 1'b0, 12'h004, 32'h0, 4'h0, "mid_read_004");
    xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, "mid_read_ws0_000");
    xfer(2, 1'b0, 12'h004, 32'h0, 4'h0, "mid_read_ws3_004");
  endtask

  initial begin
    test_reset();
    test_full();
    test_strobe();
    test_errors();
    test_abort();
    test_no_setup();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
